pair_triple_streak_detector: RTL

- Parametrised, sequential successor to the 3-input pair/triple (2-of-3 majority) detector.
- Each enabled cycle it samples an NBITS-wide input, compares its popcount against a runtime threshold, and tracks consecutive hits.
- It asserts a registered detect flag once the hit streak reaches a programmable hold length, and counts detection events.
- Sits between raw sensor/vote bits and control logic that needs debounced k-of-N decisions.

---
 rtl/pair_triple_pkg.sv | 29 ++
 rtl/pair_triple_streak_detector_popcount.sv | 26 ++
 rtl/pair_triple_streak_detector.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pair_triple_pkg.sv
// ============================================================================
// Module  : pair_triple_pkg
// Purpose : Shared FSM state type, state width and saturating-increment helper
//           used by the pair/triple streak detector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pair_triple_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE     = 2'd0,
      ARMING   = 2'd1,
      DETECTED = 2'd2
   } state_t;

   // Increment that sticks at the all-ones value of a 'width'-bit counter.
   function automatic logic [31:0] cnt_sat_inc(input logic [31:0] value,
                                                input int unsigned width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_v) ? max_v : value + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pair_triple_streak_detector_popcount.sv
// ============================================================================
// Module  : pair_triple_streak_detector_popcount
// Purpose : Combinational population count of an NBITS-wide voter vector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pair_triple_streak_detector_popcount #(
   parameter int NBITS = 3
) (
   input  logic [NBITS-1:0]             vec_i,
   output logic [$clog2(NBITS+1)-1:0]   count_o
);

   localparam int CW = $clog2(NBITS + 1);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < NBITS; i++) begin
         count_o = count_o + CW'(vec_i[i]);
      end
   end

endmodule

`default_nettype wire

// File: rtl/pair_triple_streak_detector.sv
// ============================================================================
// Module  : pair_triple_streak_detector
// Purpose : k-of-N vote detector with programmable hit-streak debounce and a
//           saturating detection-event counter. Optional exit hysteresis
//           (separate low threshold) enabled by PAIR_TRIPLE_STREAK_HYST_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pair_triple_streak_detector
   import pair_triple_pkg::*;
#(
   parameter int NBITS = 3,
   parameter int CNTW  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         clear,
   input  logic [NBITS-1:0]             in,
   input  logic [$clog2(NBITS+1)-1:0]   thresh,
`ifdef PAIR_TRIPLE_STREAK_HYST_EN
   input  logic [$clog2(NBITS+1)-1:0]   thresh_lo,
`endif
   input  logic [CNTW-1:0]              hold,
   output logic                         match,
   output logic                         detect,
   output logic                         detect_pulse,
   output logic [CNTW-1:0]              streak,
   output logic [CNTW-1:0]              events
);

   localparam int TW = $clog2(NBITS + 1);

   logic [TW-1:0]   w_count;
   logic            w_hit;
   logic            w_adv;
   logic            w_entry;
   logic [CNTW-1:0] w_h_eff;

   state_t          state_q,  state_d;
   logic            match_q,  match_d;
   logic            pulse_q,  pulse_d;
   logic [CNTW-1:0] streak_q, streak_d;
   logic [CNTW-1:0] events_q, events_d;

   pair_triple_streak_detector_popcount #(
      .NBITS (NBITS)
   ) u_popcount (
      .vec_i   (in),
      .count_o (w_count)
   );

   assign w_hit   = (w_count >= thresh);
   assign w_h_eff = (hold == '0) ? CNTW'(1) : hold;

   // w_adv is the condition that keeps the streak growing and the FSM alive;
   // with hysteresis the DETECTED state only needs the lower threshold.
   always_comb begin
      w_adv = w_hit;
`ifdef PAIR_TRIPLE_STREAK_HYST_EN
      if (state_q == DETECTED) begin
         w_adv = (w_count >= thresh_lo);
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      streak_d = streak_q;
      events_d = events_q;
      pulse_d  = 1'b0;
      w_entry  = 1'b0;
      if (en) begin
         match_d  = w_hit;
         streak_d = w_adv ? CNTW'(cnt_sat_inc(32'(streak_q), CNTW)) : '0;
         case (state_q)
            IDLE, ARMING: begin
               if (!w_adv) begin
                  state_d = IDLE;
               end else if (streak_d >= w_h_eff) begin
                  state_d = DETECTED;
               end else begin
                  state_d = ARMING;
               end
            end
            DETECTED: begin
               if (!w_adv) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
         w_entry = (state_d == DETECTED) && (state_q != DETECTED);
         pulse_d = w_entry;
         if (w_entry) begin
            events_d = CNTW'(cnt_sat_inc(32'(events_q), CNTW));
         end
      end
      if (clear) begin
         events_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         match_q  <= 1'b0;
         pulse_q  <= 1'b0;
         streak_q <= '0;
         events_q <= '0;
      end else begin
         state_q  <= state_d;
         match_q  <= match_d;
         pulse_q  <= pulse_d;
         streak_q <= streak_d;
         events_q <= events_d;
      end
   end

   assign match        = match_q;
   assign detect       = (state_q == DETECTED);
   assign detect_pulse = pulse_q;
   assign streak       = streak_q;
   assign events       = events_q;

endmodule

`default_nettype wire
